serial_adder: RTL and testbench

Bit-serial ripple adder built around a single full-adder slice and a carry flip-flop. It accepts two WIDTH-bit operands plus carry-in on a start pulse and feeds them LSB-first through the 1-bit full adder, one bit per clock. It registers the carry between bits and assembles the sum in a shift register. It is the sequential stage that drives the full-adder cell, trading WIDTH+1 cycles of latency for one adder slice.

---
 rtl/serial_adder.sv | 126 ++++++++++++
 tb/tb_serial_adder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder built around one full-adder slice.
// Operands are captured on an accepted start and added LSB-first, one bit per
// clock, with the carry held in a flip-flop between bits. The sum is assembled
// in a right-shifting register and published to s/co only at completion.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request; sampled only while not busy
//   a, b   WIDTH-bit operands, captured on accepted start
//   ci     carry-in, captured on accepted start
//   busy   high while bits are being added (registered)
//   done   one-cycle pulse when s/co hold a new result (registered)
//   s      WIDTH-bit sum, held until the next completion
//   co     final carry-out, held until the next completion
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] ra_q;
    logic [WIDTH-1:0] rb_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] s_q;
    logic             co_q;

    logic             fs_c;
    logic             fc_c;
    logic [WIDTH-1:0] sum_d;

    // Single full-adder slice on the current LSBs and the stored carry.
    assign fs_c  = ra_q[0] ^ rb_q[0] ^ carry_q;
    assign fc_c  = (ra_q[0] & rb_q[0]) | (ra_q[0] & carry_q) | (rb_q[0] & carry_q);
    // New sum bit enters at the MSB so the LSB ends up at bit 0 after WIDTH shifts.
    assign sum_d = {fs_c, sum_q[WIDTH-1:1]};

    // Control FSM and datapath; busy/done are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        ra_q    <= a;
                        rb_q    <= b;
                        carry_q <= ci;
                        sum_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ADD;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                ADD: begin
                    sum_q   <= sum_d;
                    ra_q    <= ra_q >> 1;
                    rb_q    <= rb_q >> 1;
                    carry_q <= fc_c;
                    if (cnt_q == LAST_BIT) begin
                        // Last bit: publish the whole result on this edge only.
                        s_q     <= sum_d;
                        co_q    <= fc_c;
                        cnt_q   <= '0;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state_q <= ADD;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign co   = co_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder (WIDTH=8).
// Expected {co,s} values are queued when a start is driven and compared by a
// monitor whenever done is observed.
module tb_serial_adder;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;

    int total = 0;
    int bad   = 0;

    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] last_res;
    int             done_seen;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic c);
        return (WIDTH+1)'(x) + (WIDTH+1)'(y) + (WIDTH+1)'(c);
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(0));
            end else begin
                logic [WIDTH:0] e;
                e = exp_q.pop_front();
                chk("sum", 32'(s), 32'(e[WIDTH-1:0]));
                chk("carry_out", 32'(co), 32'(e[WIDTH]));
                last_res = e;
            end
        end
    end

    // Single operation: start pulse, check busy window, held output, done timing.
    task automatic do_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                         input logic xc, input bit scramble);
        logic [WIDTH:0] held;
        held = last_res;
        @(negedge clk);
        a = xa; b = xb; ci = xc; start = 1'b1;
        exp_q.push_back(model(xa, xb, xc));
        for (int i = 1; i <= WIDTH; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (scramble) begin
                a  = WIDTH'($urandom);
                b  = WIDTH'($urandom);
                ci = 1'($urandom);
                start = 1'($urandom);
            end
            chk("busy_during_add", 32'(busy), 32'(1));
            chk("no_done_during_add", 32'(done), 32'(0));
            chk("s_held", 32'(s), 32'(held[WIDTH-1:0]));
        end
        start = 1'b0;
        @(negedge clk);
        chk("done_timing", 32'(done), 32'(1));
        chk("busy_fall", 32'(busy), 32'(0));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'(0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
        last_res = '0;
        done_seen = 0;

        // Reset held for three cycles, outputs cleared throughout.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_done", 32'(done), 32'(0));
            chk("rst_s", 32'(s), 32'(0));
            chk("rst_co", 32'(co), 32'(0));
        end

        // Start asserted on the first post-reset edge.
        rst = 1'b0; a = 8'h01; b = 8'h02; ci = 1'b1; start = 1'b1;
        exp_q.push_back(model(8'h01, 8'h02, 1'b1));
        @(negedge clk);
        start = 1'b0;
        chk("first_accept_busy", 32'(busy), 32'(1));
        repeat (WIDTH) @(negedge clk);
        chk("first_done", 32'(done), 32'(1));
        @(negedge clk);

        do_op(8'h3C, 8'h42, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(8'hA5, 8'h5A, 1'b1, 1'b0);
        do_op(8'h80, 8'h80, 1'b1, 1'b0);
        do_op(8'h00, 8'h00, 1'b0, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0);

        // Operands (and start) toggled mid-ADD: captured values only.
        do_op(8'h12, 8'h34, 1'b0, 1'b1);

        // Back-to-back with start held high: one accept per WIDTH+1 cycles.
        begin
            int n_ops;
            int cyc;
            n_ops = 5;
            @(negedge clk);
            a = WIDTH'($urandom); b = WIDTH'($urandom); ci = 1'($urandom);
            start = 1'b1;
            exp_q.push_back(model(a, b, ci));
            for (int k = 0; k < n_ops; k++) begin
                cyc = 0;
                do begin
                    @(negedge clk);
                    cyc++;
                end while (done !== 1'b1 && cyc < 30);
                chk("b2b_period", 32'(cyc), 32'(WIDTH + 1));
                if (k < n_ops - 1) begin
                    a = WIDTH'($urandom); b = WIDTH'($urandom); ci = 1'($urandom);
                    exp_q.push_back(model(a, b, ci));
                end else begin
                    start = 1'b0;
                end
            end
            @(negedge clk);
            chk("b2b_idle", 32'(busy), 32'(0));
        end

        // Reset in the 4th cycle of an ADD: abort, no done, outputs cleared.
        @(negedge clk);
        a = 8'h77; b = 8'h11; ci = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_s", 32'(s), 32'(0));
        chk("abort_co", 32'(co), 32'(0));
        last_res = '0;
        begin
            int d0;
            d0 = done_seen;
            repeat (WIDTH + 2) @(negedge clk);
            chk("abort_no_done", 32'(done_seen), 32'(d0));
        end
        do_op(8'hC3, 8'h3D, 1'b1, 1'b0);

        // Reset and start on the same edge: start dropped.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 8'h55; b = 8'h55;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        last_res = '0;
        @(negedge clk);
        chk("rst_wins_busy", 32'(busy), 32'(0));
        chk("rst_wins_s", 32'(s), 32'(0));
        repeat (WIDTH + 2) @(negedge clk);
        chk("leftover_expect", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
